approx_bk_adder_pipe: RTL

APPROX_BK_ADDER_PIPE -- requirements
Module: approx_bk_adder_pipe

---
 rtl/approx_adder_pkg.sv | 20 ++
 rtl/approx_bk_adder_pipe_if.sv | 34 +++
 rtl/bk_prefix_cell.sv | 16 +
 rtl/approx_bk_adder_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_adder_pkg.sv
// Shared defaults and elaboration helpers for the approximate Brent-Kung adder.
// Latency: none (constants and constant functions only).
// Backpressure: not applicable.
package approx_adder_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_APPROX_K = 2;
  localparam int DEF_CNT_W    = 32;

  // Number of Brent-Kung prefix levels, i.e. ceil(log2(width)).
  function automatic int prefix_levels(input int width);
    int lv;
    lv = 0;
    while ((1 << lv) < width) begin
      lv++;
    end
    return lv;
  endfunction

endpackage

// File: rtl/approx_bk_adder_pipe_if.sv
// Operand and result handshake bundle for approx_bk_adder_pipe.
// Latency: none (wires only).
// Backpressure: valid/ready on both the operand side and the result side.
interface approx_bk_adder_pipe_if
  import approx_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             In_Valid;
  logic             In_Ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Carry_in;
  logic             Approx_En;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Sum;
  logic             Carry_Out;
  logic             Mismatch;

  // Producer of operands and consumer of results.
  modport master (
    output In_Valid, A, B, Carry_in, Approx_En, Out_Ready,
    input  In_Ready, Out_Valid, Sum, Carry_Out, Mismatch
  );

  // The adder itself.
  modport slave (
    input  In_Valid, A, B, Carry_in, Approx_En, Out_Ready,
    output In_Ready, Out_Valid, Sum, Carry_Out, Mismatch
  );

endinterface

// File: rtl/bk_prefix_cell.sv
// Brent-Kung prefix operator: merges a high group (gh,ph) with the adjacent low group (gl,pl).
// Latency: combinational.
// Backpressure: not applicable.
module bk_prefix_cell (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);

  assign g = gh | (ph & gl);
  assign p = ph & pl;

endmodule

// File: rtl/approx_bk_adder_pipe.sv
// Pipelined Brent-Kung adder with optional approximate low-order carries and error statistics.
// Latency: 2 cycles from acceptance to Out_Valid, one item per cycle.
// Backpressure: Out_Ready low freezes stage 2; In_Ready drops once both stages hold items.
module approx_bk_adder_pipe
  import approx_adder_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int APPROX_K = DEF_APPROX_K,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  approx_bk_adder_pipe_if.slave bus,
  input  logic                 Cnt_Clr,
  output logic [CNT_W-1:0]     Txn_Count,
  output logic [CNT_W-1:0]     Err_Count
);

  localparam int LVL = prefix_levels(WIDTH);
  // Lane 0 carries the exact sum (Carry_in folded into bit 0);
  // lane 1 carries the approximate sum (bits below APPROX_K-1 masked off).
  localparam int NL  = 2;

  typedef struct packed {
    logic                     approx;
    logic                     cin;
    logic [WIDTH-1:0]         p;
    logic [WIDTH-1:0]         g;
    logic [NL-1:0][WIDTH-1:0] ug;
    logic [NL-1:0][WIDTH-1:0] up;
  } s1_t;

  // ---------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------
  logic s1_vld;
  logic s2_vld;
  logic s1_en;
  logic s2_en;
  logic out_fire;

  assign s2_en        = !s2_vld || bus.Out_Ready;
  assign s1_en        = !s1_vld || s2_en;
  assign bus.In_Ready = s1_en;
  assign out_fire     = s2_vld && bus.Out_Ready;

  // ---------------------------------------------------------------------
  // Stage 1: bit-level propagate/generate and lane inputs
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] keep_mask;
  logic [WIDTH-1:0] lane_g [NL];
  logic [WIDTH-1:0] lane_p [NL];
  logic [WIDTH-1:0] up_g   [NL];
  logic [WIDTH-1:0] up_p   [NL];
  logic [WIDTH-1:0] dn_g   [NL];
  logic [WIDTH-1:0] dn_p   [NL];

  s1_t s1_d;
  s1_t s1_q;

  // Build the exact and approximate lane inputs from the raw operands.
  always_comb begin
    p_in      = bus.A ^ bus.B;
    g_in      = bus.A & bus.B;
    keep_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      keep_mask[i] = (i >= APPROX_K - 1);
    end
    lane_p[0]    = p_in;
    lane_g[0]    = g_in;
    lane_g[0][0] = g_in[0] | (p_in[0] & bus.Carry_in);
    lane_p[1]    = p_in & keep_mask;
    lane_g[1]    = g_in & keep_mask;
  end

  // ---------------------------------------------------------------------
  // Prefix trees: up-sweep feeds stage 1, down-sweep runs from stage 1 regs
  // ---------------------------------------------------------------------
  for (genvar ln = 0; ln < NL; ln++) begin : g_lane
    logic [WIDTH-1:0] ug [LVL+1];
    logic [WIDTH-1:0] up [LVL+1];
    logic [WIDTH-1:0] dg [LVL];
    logic [WIDTH-1:0] dp [LVL];

    assign ug[0] = lane_g[ln];
    assign up[0] = lane_p[ln];

    // Up-sweep: at level l, bit i with (i+1) a multiple of 2^l absorbs the
    // group 2^(l-1) below it; after LVL levels bit 2^l-1 holds [2^l-1:0].
    for (genvar l = 1; l <= LVL; l++) begin : g_up
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i + 1) % (1 << l)) == 0) begin : g_cell
          bk_prefix_cell u_cell (
            .gh (ug[l-1][i]),
            .ph (up[l-1][i]),
            .gl (ug[l-1][i-(1<<(l-1))]),
            .pl (up[l-1][i-(1<<(l-1))]),
            .g  (ug[l][i]),
            .p  (up[l][i])
          );
        end else begin : g_pass
          assign ug[l][i] = ug[l-1][i];
          assign up[l][i] = up[l-1][i];
        end
      end
    end

    assign up_g[ln] = ug[LVL];
    assign up_p[ln] = up[LVL];

    assign dg[LVL-1] = s1_q.ug[ln];
    assign dp[LVL-1] = s1_q.up[ln];

    // Down-sweep: fill the bits halfway between completed prefixes, widest
    // span first, so every bit ends up holding the full [i:0] prefix.
    for (genvar l = LVL - 1; l >= 1; l--) begin : g_dn
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if ((((i + 1) % (1 << l)) == (1 << (l - 1))) &&
            (i >= (1 << l) + (1 << (l - 1)) - 1)) begin : g_cell
          bk_prefix_cell u_cell (
            .gh (dg[l][i]),
            .ph (dp[l][i]),
            .gl (dg[l][i-(1<<(l-1))]),
            .pl (dp[l][i-(1<<(l-1))]),
            .g  (dg[l-1][i]),
            .p  (dp[l-1][i])
          );
        end else begin : g_pass
          assign dg[l-1][i] = dg[l][i];
          assign dp[l-1][i] = dp[l][i];
        end
      end
    end

    assign dn_g[ln] = dg[0];
    assign dn_p[ln] = dp[0];
  end

  // Full-span propagate terms are not needed once the prefixes are complete.
  logic unused_dn_p;
  assign unused_dn_p = ^{dn_p[0], dn_p[1]};

  // Gather everything stage 1 has to hold for the down-sweep and sum.
  always_comb begin
    s1_d        = '0;
    s1_d.approx = bus.Approx_En;
    s1_d.cin    = bus.Carry_in;
    s1_d.p      = p_in;
    s1_d.g      = g_in;
    for (int ln = 0; ln < NL; ln++) begin
      s1_d.ug[ln] = up_g[ln];
      s1_d.up[ln] = up_p[ln];
    end
  end

  // Stage 1 register: capture a new item whenever the stage can advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
    end else if (s1_en) begin
      s1_vld <= bus.In_Valid;
      if (bus.In_Valid) begin
        s1_q <= s1_d;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: carries, sums, mode select and error flag
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   c_ex;
  logic [WIDTH:0]   c_ap;
  logic [WIDTH-1:0] sum_ex;
  logic [WIDTH-1:0] sum_ap;
  logic             use_ap;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             mis_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             mis_q;

  // Exact carries come straight from lane 0; approximate carries use the
  // raw generate bits for the lowest APPROX_K positions and lane 1 above.
  always_comb begin
    c_ex = {dn_g[0], s1_q.cin};
    c_ap = '0;
    for (int i = 1; i <= WIDTH; i++) begin
      c_ap[i] = (i <= APPROX_K) ? s1_q.g[i-1] : dn_g[1][i-1];
    end
    sum_ex = s1_q.p ^ c_ex[WIDTH-1:0];
    sum_ap = s1_q.p ^ c_ap[WIDTH-1:0];
    use_ap = (APPROX_K > 0) && s1_q.approx;
    sum_d  = use_ap ? sum_ap : sum_ex;
    cout_d = use_ap ? c_ap[WIDTH] : c_ex[WIDTH];
    mis_d  = use_ap && ({c_ap[WIDTH], sum_ap} != {c_ex[WIDTH], sum_ex});
  end

  // Stage 2 register: results only move when the consumer has taken the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      mis_q  <= 1'b0;
    end else if (s2_en) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        mis_q  <= mis_d;
      end
    end
  end

  assign bus.Out_Valid = s2_vld;
  assign bus.Sum       = sum_q;
  assign bus.Carry_Out = cout_q;
  assign bus.Mismatch  = mis_q;

  // ---------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------
  // Saturating delivery/error counters; a clear overrides any increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Txn_Count <= '0;
      Err_Count <= '0;
    end else if (Cnt_Clr) begin
      Txn_Count <= '0;
      Err_Count <= '0;
    end else if (out_fire) begin
      if (Txn_Count != '1) begin
        Txn_Count <= Txn_Count + CNT_W'(1);
      end
      if (mis_q && (Err_Count != '1)) begin
        Err_Count <= Err_Count + CNT_W'(1);
      end
    end
  end

endmodule
